// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM states, algorithm select, shift-count width.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   typedef enum logic {
      MODE_SUB = 1'b0,
      MODE_BIN = 1'b1
   } mode_e;

   // Stein can strip at most BusSize common factors of two, so k needs to hold 0..BusSize.
   function automatic int k_width(input int bus_size);
      return $clog2(bus_size + 1);
   endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Operand-in and result-out valid/ready channels of the GCD engine.
interface gcd_engine_if #(
   parameter int BusSize = 8,
   parameter int CycW    = 16
);
   logic               in_valid_i;
   logic               in_ready_o;
   logic [BusSize-1:0] a_i;
   logic [BusSize-1:0] b_i;
   logic               mode_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [BusSize-1:0] gcd_o;
   logic [CycW-1:0]    cycles_o;
   logic               busy_o;

   modport slave (
      input  in_valid_i, a_i, b_i, mode_i, out_ready_i,
      output in_ready_o, out_valid_o, gcd_o, cycles_o, busy_o
   );

   modport master (
      output in_valid_i, a_i, b_i, mode_i, out_ready_i,
      input  in_ready_o, out_valid_o, gcd_o, cycles_o, busy_o
   );
endinterface

// File: rtl/gcd_step.sv
// One combinational GCD iteration for either Euclid-by-subtraction or binary (Stein).
// result is only meaningful when eq is set; nA/nB/nk are then don't-care.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int  BusSize = 8,
   localparam int KW      = k_width(BusSize)
) (
   input  logic [BusSize-1:0] a,
   input  logic [BusSize-1:0] b,
   input  logic [KW-1:0]      k,
   input  mode_e              mode,
   output logic [BusSize-1:0] na,
   output logic [BusSize-1:0] nb,
   output logic [KW-1:0]      nk,
   output logic               eq,
   output logic [BusSize-1:0] result
);

   always_comb begin
      na     = a;
      nb     = b;
      nk     = k;
      eq     = (a == b);
      result = a;
      if (mode == MODE_SUB) begin
         if (a < b) begin
            na = b;
            nb = a;
         end else begin
            na = a - b;
         end
      end else begin
         // gcd <= min(a,b), so the restored power of two always fits in BusSize.
         result = a << k;
         if (!a[0] && !b[0]) begin
            na = a >> 1;
            nb = b >> 1;
            nk = k + KW'(1);
         end else if (!a[0]) begin
            na = a >> 1;
         end else if (!b[0]) begin
            nb = b >> 1;
         end else if (a > b) begin
            na = (a - b) >> 1;
         end else begin
            nb = (b - a) >> 1;
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: one algorithm step per cycle, result valid cycles+1 edges after accept (zero operand: next cycle).
// Holds result in DONE until out_ready_i; no new pair is accepted until the result has been taken.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int BusSize = 8,
   parameter int CycW    = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   gcd_engine_if.slave bus
);

   localparam int KW = k_width(BusSize);

   state_e             state_q, state_d;
   logic [BusSize-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
   logic [KW-1:0]      k_q, k_d;
   mode_e              mode_q, mode_d;
   logic [CycW-1:0]    cnt_q, cnt_d;

   logic [BusSize-1:0] step_a, step_b, step_result;
   logic [KW-1:0]      step_k;
   logic               step_eq;

   gcd_step #(.BusSize(BusSize)) u_step (
      .a      (a_q),
      .b      (b_q),
      .k      (k_q),
      .mode   (mode_q),
      .na     (step_a),
      .nb     (step_b),
      .nk     (step_k),
      .eq     (step_eq),
      .result (step_result)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         mode_q  <= MODE_SUB;
         cnt_q   <= '0;
         gcd_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         gcd_q   <= gcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      gcd_d   = gcd_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid_i) begin
               a_d    = bus.a_i;
               b_d    = bus.b_i;
               mode_d = mode_e'(bus.mode_i);
               k_d    = '0;
               cnt_d  = '0;
               // A zero operand has a closed-form answer; skip RUN entirely.
               if (bus.a_i == '0 || bus.b_i == '0) begin
                  gcd_d   = bus.a_i | bus.b_i;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (cnt_q != '1) cnt_d = cnt_q + CycW'(1);
            if (step_eq) begin
               gcd_d   = step_result;
               state_d = DONE;
            end else begin
               a_d = step_a;
               b_d = step_b;
               k_d = step_k;
            end
         end
         DONE: begin
            if (bus.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.gcd_o       = gcd_q;
   assign bus.cycles_o    = cnt_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed vector table plus corner sequences and a random sweep against a modulo-Euclid reference.
module tb_gcd_engine;

   localparam int LAT_MAX = 2000;

   logic clk_i;
   logic rst_ni;

   gcd_engine_if #(.BusSize(8), .CycW(16)) bus ();
   gcd_engine_if #(.BusSize(8), .CycW(4))  bus4 ();

   gcd_engine #(.BusSize(8), .CycW(16)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   gcd_engine #(.BusSize(8), .CycW(4)) dut4 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus4)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       mode;
      logic [7:0] g;
      int         cyc;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Presents a pair, returns edges from the accept edge (inclusive) until out_valid is seen.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic m, output int lat);
      int t;
      t = 0;
      while (!bus.in_ready_o && t < LAT_MAX) begin
         @(posedge clk_i); #1;
         t++;
      end
      bus.in_valid_i = 1'b1;
      bus.a_i        = a;
      bus.b_i        = b;
      bus.mode_i     = m;
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      bus.a_i        = 8'($urandom);
      bus.b_i        = 8'($urandom);
      bus.mode_i     = 1'($urandom);
      lat = 1;
      while (!bus.out_valid_o && lat < LAT_MAX) begin
         @(posedge clk_i); #1;
         lat++;
      end
   endtask

   task automatic drain();
      bus.out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      bus.out_ready_i = 1'b0;
   endtask

   vec_t vecs[12];

   initial begin
      int         lat, t, bad_g, bad_c, bad_r, bad_v;
      logic [7:0] g0;
      logic [15:0] c0;
      int         a, b, m;

      vecs[0]  = '{8'd12,  8'd8,   1'b0, 8'd4,   4};
      vecs[1]  = '{8'd12,  8'd8,   1'b1, 8'd4,   5};
      vecs[2]  = '{8'd48,  8'd18,  1'b1, 8'd6,   6};
      vecs[3]  = '{8'd0,   8'd5,   1'b0, 8'd5,   0};
      vecs[4]  = '{8'd0,   8'd5,   1'b1, 8'd5,   0};
      vecs[5]  = '{8'd0,   8'd0,   1'b0, 8'd0,   0};
      vecs[6]  = '{8'd5,   8'd0,   1'b1, 8'd5,   0};
      vecs[7]  = '{8'd7,   8'd7,   1'b0, 8'd7,   1};
      vecs[8]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1};
      vecs[9]  = '{8'd9,   8'd6,   1'b0, 8'd3,   4};
      vecs[10] = '{8'd9,   8'd6,   1'b1, 8'd3,   3};
      vecs[11] = '{8'd128, 8'd64,  1'b1, 8'd64,  8};

      rst_ni           = 1'b0;
      bus.in_valid_i   = 1'b0;
      bus.a_i          = '0;
      bus.b_i          = '0;
      bus.mode_i       = 1'b0;
      bus.out_ready_i  = 1'b0;
      bus4.in_valid_i  = 1'b0;
      bus4.a_i         = '0;
      bus4.b_i         = '0;
      bus4.mode_i      = 1'b0;
      bus4.out_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      chk("reset_in_ready",  bus.in_ready_o,  1);
      chk("reset_out_valid", bus.out_valid_o, 0);
      chk("reset_busy",      bus.busy_o,      0);
      chk("reset_gcd",       bus.gcd_o,       0);
      chk("reset_cycles",    bus.cycles_o,    0);

      for (int i = 0; i < 12; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].mode, lat);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].cyc + 1);
         chk($sformatf("vec%0d_gcd", i), bus.gcd_o, vecs[i].g);
         chk($sformatf("vec%0d_cycles", i), bus.cycles_o, vecs[i].cyc);
         drain();
         chk($sformatf("vec%0d_ready_after", i), bus.in_ready_o, 1);
      end

      // Backpressure: result must sit still while the consumer stalls.
      launch(8'd9, 8'd6, 1'b0, lat);
      g0 = bus.gcd_o;
      c0 = bus.cycles_o;
      chk("bp_gcd", g0, 3);
      bad_g = 0; bad_c = 0; bad_r = 0; bad_v = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         if (bus.gcd_o != g0)    bad_g++;
         if (bus.cycles_o != c0) bad_c++;
         if (bus.in_ready_o)     bad_r++;
         if (!bus.out_valid_o)   bad_v++;
      end
      chk("bp_gcd_stable",    bad_g, 0);
      chk("bp_cycles_stable", bad_c, 0);
      chk("bp_in_ready_low",  bad_r, 0);
      chk("bp_valid_held",    bad_v, 0);
      drain();
      chk("bp_release_valid", bus.out_valid_o, 0);
      chk("bp_release_ready", bus.in_ready_o,  1);
      chk("bp_release_busy",  bus.busy_o,      0);

      // Reset in the middle of a long subtract run.
      bus.in_valid_i = 1'b1;
      bus.a_i        = 8'd255;
      bus.b_i        = 8'd1;
      bus.mode_i     = 1'b0;
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
      repeat (49) @(posedge clk_i);
      #1;
      chk("mid_busy",   bus.busy_o,   1);
      chk("mid_cycles", bus.cycles_o, 49);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_cycles",    bus.cycles_o,    0);
      chk("rst_in_ready",  bus.in_ready_o,  1);
      chk("rst_busy",      bus.busy_o,      0);
      launch(8'd12, 8'd8, 1'b0, lat);
      chk("post_rst_latency", lat, 5);
      chk("post_rst_gcd",     bus.gcd_o, 4);
      chk("post_rst_cycles",  bus.cycles_o, 4);
      drain();

      // Narrow counter must saturate, not wrap, over 255 steps.
      bus4.in_valid_i = 1'b1;
      bus4.a_i        = 8'd255;
      bus4.b_i        = 8'd1;
      bus4.mode_i     = 1'b0;
      @(posedge clk_i); #1;
      bus4.in_valid_i = 1'b0;
      t = 0;
      while (!bus4.out_valid_o && t < LAT_MAX) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("sat_latency", t, 255);
      chk("sat_gcd",     bus4.gcd_o, 1);
      chk("sat_cycles",  bus4.cycles_o, 15);
      bus4.out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      bus4.out_ready_i = 1'b0;
      chk("sat_release", bus4.in_ready_o, 1);

      for (int i = 0; i < 400; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         m = i % 2;
         launch(8'(a), 8'(b), 1'(m), lat);
         chk($sformatf("sweep_gcd m%0d %0d,%0d", m, a, b), bus.gcd_o, ref_gcd(a, b));
         chk($sformatf("sweep_latency m%0d %0d,%0d", m, a, b), lat, int'(bus.cycles_o) + 1);
         if (m == 1)
            chk($sformatf("sweep_bin_bound %0d,%0d", a, b), (bus.cycles_o <= 16'd17), 1);
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
